// File: rtl/mem_access.sv
// MEM-stage load/store engine: byte-serial little-endian accesses on an 8-bit
// single-port RAM, stalling upstream until the access completes.
module mem_access #(
  parameter int             OPW    = 8,
  parameter logic [OPW-1:0] OP_LB  = 8'h20,
  parameter logic [OPW-1:0] OP_LH  = 8'h21,
  parameter logic [OPW-1:0] OP_LW  = 8'h22,
  parameter logic [OPW-1:0] OP_LBU = 8'h23,
  parameter logic [OPW-1:0] OP_LHU = 8'h24,
  parameter logic [OPW-1:0] OP_SB  = 8'h28,
  parameter logic [OPW-1:0] OP_SH  = 8'h29,
  parameter logic [OPW-1:0] OP_SW  = 8'h2A
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_en,
  input  logic [OPW-1:0] aluop_i,
  input  logic [31:0]    mem_addr_i,
  input  logic [31:0]    rt_data_i,
  input  logic [4:0]     waddr_i,
  input  logic           we_i,
  input  logic [31:0]    wdata_i,
  output logic [4:0]     waddr_o,
  output logic           we_o,
  output logic [31:0]    wdata_o,
  output logic           stall_req,
  output logic [31:0]    ram_addr,
  output logic           ram_wr,
  output logic [7:0]     ram_dout,
  input  logic [7:0]     ram_din
);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [23:0] lbuf;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        sext;
  logic [2:0]  size;
  logic        last;
  logic [31:0] rt_shift;
  logic [31:0] load_val;

  // Op decode; an unrecognised aluop falls through as a non-memory op.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = 3'd0;
    if (mem_en) begin
      case (aluop_i)
        OP_LB:   begin is_load  = 1'b1; size = 3'd1; sext = 1'b1; end
        OP_LH:   begin is_load  = 1'b1; size = 3'd2; sext = 1'b1; end
        OP_LW:   begin is_load  = 1'b1; size = 3'd4; end
        OP_LBU:  begin is_load  = 1'b1; size = 3'd1; end
        OP_LHU:  begin is_load  = 1'b1; size = 3'd2; end
        OP_SB:   begin is_store = 1'b1; size = 3'd1; end
        OP_SH:   begin is_store = 1'b1; size = 3'd2; end
        OP_SW:   begin is_store = 1'b1; size = 3'd4; end
        default: begin is_load  = 1'b0; is_store = 1'b0; end
      endcase
    end
  end

  assign is_mem   = is_load | is_store;
  assign last     = ({1'b0, cnt} == (size - 3'd1));
  assign rt_shift = rt_data_i >> {cnt, 3'b000};

  // The final load byte arrives on ram_din in FIN and is merged without a register.
  always_comb begin
    case (size)
      3'd1:    load_val = sext ? {{24{ram_din[7]}}, ram_din} : {24'h0, ram_din};
      3'd2:    load_val = sext ? {{16{ram_din[7]}}, ram_din, lbuf[7:0]}
                               : {16'h0, ram_din, lbuf[7:0]};
      default: load_val = {ram_din, lbuf[23:0]};
    endcase
  end

  always_comb begin
    waddr_o   = 5'd0;
    we_o      = 1'b0;
    wdata_o   = 32'h0;
    stall_req = 1'b0;
    ram_addr  = 32'h0;
    ram_wr    = 1'b0;
    ram_dout  = 8'h0;
    if (!rst) begin
      waddr_o = waddr_i;
      if (!is_mem) begin
        we_o    = we_i;
        wdata_o = wdata_i;
      end else begin
        case (state)
          IDLE, XFER: begin
            ram_addr  = mem_addr_i + {30'h0, cnt};
            ram_wr    = is_store;
            ram_dout  = rt_shift[7:0];
            stall_req = !(is_store && last);
          end
          FIN: begin
            we_o    = we_i;
            wdata_o = load_val;
          end
          default: stall_req = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      lbuf  <= 24'h0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            if (size == 3'd1) begin
              state <= is_load ? FIN : IDLE;
            end else begin
              state <= XFER;
              cnt   <= 2'd1;
            end
          end
        end
        XFER: begin
          if (!is_mem) begin
            state <= IDLE;
            cnt   <= 2'd0;
          end else begin
            if (is_load) lbuf[{cnt - 2'd1, 3'b000} +: 8] <= ram_din;
            if (last) begin
              state <= is_store ? IDLE : FIN;
              cnt   <= 2'd0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          cnt   <= 2'd0;
          lbuf  <= 24'h0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule
